// File: rtl/mp_icache_ctrl_sequencer.sv
// Multi-bank icache control sequencer: enable/disable/flush handshake over a bank mask
// with drain on disable. Per-bank perf counters are built only with ICACHE_CTRL_PERF_CNT_EN.

module mp_icache_ctrl_bank_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 hit_evt,
    input  logic                 trans_evt,
    input  logic                 miss_evt,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] trans_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);
    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c, input logic ev);
        return (ev && c != '1) ? c + 1'b1 : c;
    endfunction

    // clear has priority over a coincident event
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr) begin
            hit_cnt   <= '0;
            trans_cnt <= '0;
            miss_cnt  <= '0;
        end else if (en) begin
            hit_cnt   <= bump(hit_cnt, hit_evt);
            trans_cnt <= bump(trans_cnt, trans_evt);
            miss_cnt  <= bump(miss_cnt, miss_evt);
        end
    end
endmodule

module mp_icache_ctrl_sequencer #(
    parameter int  NB_BANKS  = 4,
    parameter int  CNT_WIDTH = 32,
    localparam int BW        = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [NB_BANKS-1:0]  cmd_mask_i,
    output logic                 done_o,
    output logic [NB_BANKS-1:0]  req_enable_o,
    output logic [NB_BANKS-1:0]  req_disable_o,
    output logic [NB_BANKS-1:0]  flush_req_o,
    input  logic [NB_BANKS-1:0]  ack_enable_i,
    input  logic [NB_BANKS-1:0]  ack_disable_i,
    input  logic [NB_BANKS-1:0]  flush_ack_i,
    input  logic [NB_BANKS-1:0]  pending_trans_i,
    output logic [NB_BANKS-1:0]  enabled_o,
    input  logic                 cnt_enable_i,
    input  logic [NB_BANKS-1:0]  hit_evt_i,
    input  logic [NB_BANKS-1:0]  trans_evt_i,
    input  logic [NB_BANKS-1:0]  miss_evt_i,
    input  logic [BW-1:0]        cnt_bank_i,
    input  logic [1:0]           cnt_sel_i,
    output logic [CNT_WIDTH-1:0] cnt_rdata_o
);
    typedef enum logic [1:0] {OP_EN = 2'd0, OP_DIS = 2'd1, OP_FLUSH = 2'd2, OP_CLR = 2'd3} op_t;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          op;
    logic [NB_BANKS-1:0] mask, acked, enabled;
    logic [NB_BANKS-1:0] req_vec, ack_vec, ack_hit;
    logic                accept, all_acked;

    assign accept    = cmd_valid_i && (state == IDLE);
    assign req_vec   = (state == REQ) ? (mask & ~acked) : '0;
    assign ack_hit   = req_vec & ack_vec;
    assign all_acked = ((acked | ack_hit) & mask) == mask;
    assign enabled_o = enabled;

    always_comb begin
        ack_vec = '0;
        case (op)
            OP_EN:    ack_vec = ack_enable_i;
            OP_DIS:   ack_vec = ack_disable_i;
            OP_FLUSH: ack_vec = flush_ack_i;
            default:  ack_vec = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept)
                       state_nxt = (cmd_op_i == OP_CLR || cmd_mask_i == '0) ? DONE : REQ;
            REQ:   if (all_acked) state_nxt = (op == OP_DIS) ? DRAIN : DONE;
            DRAIN: if ((pending_trans_i & mask) == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o   = (state == IDLE);
        done_o        = (state == DONE);
        req_enable_o  = (op == OP_EN)    ? req_vec : '0;
        req_disable_o = (op == OP_DIS)   ? req_vec : '0;
        flush_req_o   = (op == OP_FLUSH) ? req_vec : '0;
    end

    // ack_hit is only non-zero in REQ, so enabled tracks accepted acks only
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op      <= '0;
            mask    <= '0;
            acked   <= '0;
            enabled <= '0;
        end else begin
            if (accept) begin
                op    <= cmd_op_i;
                mask  <= cmd_mask_i;
                acked <= '0;
            end else begin
                acked <= acked | ack_hit;
            end
            if (op == OP_EN)       enabled <= enabled | ack_hit;
            else if (op == OP_DIS) enabled <= enabled & ~ack_hit;
        end
    end

`ifdef ICACHE_CTRL_PERF_CNT_EN
    logic [NB_BANKS-1:0]                 cnt_clr;
    logic [NB_BANKS-1:0][CNT_WIDTH-1:0]  hit_cnt, trans_cnt, miss_cnt;
    logic [2**BW-1:0][CNT_WIDTH-1:0]     rd_tab;

    assign cnt_clr = (accept && cmd_op_i == OP_CLR) ? cmd_mask_i : '0;

    // read table padded to 2**BW so out-of-range bank selects read 0
    for (genvar b = 0; b < 2**BW; b++) begin : g_bank
        if (b < NB_BANKS) begin : g_cnt
            logic [CNT_WIDTH-1:0] sel_cnt;
            mp_icache_ctrl_bank_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .clr       (cnt_clr[b]),
                .en        (cnt_enable_i),
                .hit_evt   (hit_evt_i[b]),
                .trans_evt (trans_evt_i[b]),
                .miss_evt  (miss_evt_i[b]),
                .hit_cnt   (hit_cnt[b]),
                .trans_cnt (trans_cnt[b]),
                .miss_cnt  (miss_cnt[b])
            );
            always_comb begin
                sel_cnt = '0;
                case (cnt_sel_i)
                    2'd0:    sel_cnt = hit_cnt[b];
                    2'd1:    sel_cnt = trans_cnt[b];
                    2'd2:    sel_cnt = miss_cnt[b];
                    default: sel_cnt = '0;
                endcase
            end
            assign rd_tab[b] = sel_cnt;
        end else begin : g_pad
            assign rd_tab[b] = '0;
        end
    end

    assign cnt_rdata_o = rd_tab[cnt_bank_i];
`else
    logic unused_cnt;
    assign unused_cnt  = ^{cnt_enable_i, hit_evt_i, trans_evt_i, miss_evt_i, cnt_bank_i, cnt_sel_i};
    assign cnt_rdata_o = '0;
`endif
endmodule

// File: tb/tb_mp_icache_ctrl_sequencer.sv
// Scoreboarded bench for mp_icache_ctrl_sequencer (4 banks, 8-bit counters).
// Counter expectations follow ICACHE_CTRL_PERF_CNT_EN, like the design.

module tb_mp_icache_ctrl_sequencer;
    localparam int NB = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, done;
    logic [1:0]    cmd_op;
    logic [NB-1:0] cmd_mask, req_en, req_dis, flush_req;
    logic [NB-1:0] ack_en, ack_dis, flush_ack, pending, enabled;
    logic          cnt_en;
    logic [NB-1:0] hit_evt, trans_evt, miss_evt;
    logic [1:0]    cnt_bank, cnt_sel;
    logic [CW-1:0] cnt_rdata;

    typedef struct {
        string         tag;
        logic [NB-1:0] en;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, n_done = 0;

    always #5 clk = ~clk;

    mp_icache_ctrl_sequencer #(.NB_BANKS(NB), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_mask_i(cmd_mask),
        .done_o(done),
        .req_enable_o(req_en), .req_disable_o(req_dis), .flush_req_o(flush_req),
        .ack_enable_i(ack_en), .ack_disable_i(ack_dis), .flush_ack_i(flush_ack),
        .pending_trans_i(pending), .enabled_o(enabled),
        .cnt_enable_i(cnt_en), .hit_evt_i(hit_evt), .trans_evt_i(trans_evt), .miss_evt_i(miss_evt),
        .cnt_bank_i(cnt_bank), .cnt_sel_i(cnt_sel), .cnt_rdata_o(cnt_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // inputs change and outputs are sampled 4 time units after each rising edge
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #4;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [NB-1:0] m);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = m;
        step();
        cmd_valid = 1'b0;
        cmd_mask  = '0;
    endtask

    task automatic wait_ready(input string tag, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc && !cmd_ready; i++) step();
        chk(tag, cmd_ready, 1);
    endtask

    function automatic int sat(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // completion monitor: every done pulse consumes one expected entry
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.tag, enabled, e.en);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0;
        ack_en = '0; ack_dis = '0; flush_ack = '0; pending = '0;
        cnt_en = 1'b0; hit_evt = '0; trans_evt = '0; miss_evt = '0;
        cnt_bank = '0; cnt_sel = '0;
        step(3);
        rst_n = 1'b1;
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_reqs", {req_en, req_dis, flush_req}, 0);
        chk("rst_enabled", enabled, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt_rdata, 0);

        // ENABLE 0101: bank0 acks in first REQ cycle (with a stray unmasked ack on bank1)
        sb.push_back('{"en_0101_enabled", 4'b0101});
        issue(2'd0, 4'b0101);
        chk("en_req_initial", req_en, 4'b0101);
        chk("en_ready_low", cmd_ready, 0);
        ack_en = 4'b0011;
        step();
        ack_en = '0;
        chk("en_req_after_ack0", req_en, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            chk("en_req_hold", req_en, 4'b0100);
            chk("en_no_done", done, 0);
            step();
        end
        ack_en = 4'b0100;
        step();
        ack_en = '0;
        chk("en_req_after_ack2", req_en, 0);
        chk("en_done", done, 1);
        step();
        chk("en_done_one_cycle", done, 0);
        chk("en_ready_back", cmd_ready, 1);

        // DISABLE 0001 with pending held 4 cycles after the ack
        sb.push_back('{"dis_0001_enabled", 4'b0100});
        pending = 4'b0011;
        issue(2'd1, 4'b0001);
        chk("dis_req", req_dis, 4'b0001);
        ack_dis = 4'b0001;
        step();
        ack_dis = '0;
        chk("dis_req_drop", req_dis, 0);
        for (int i = 0; i < 4; i++) begin
            chk("dis_drain_no_done", done, 0);
            step();
        end
        pending = 4'b0010;  // unmasked bank still busy: must not block
        chk("dis_drain_last", done, 0);
        step();
        pending = '0;
        chk("dis_done", done, 1);
        chk("dis_enabled0", enabled[0], 0);
        wait_ready("dis_ready", 10);

        // FLUSH with empty mask completes immediately without requests
        sb.push_back('{"flush_empty_enabled", 4'b0100});
        issue(2'd2, 4'b0000);
        chk("flush_empty_done", done, 1);
        chk("flush_empty_req", flush_req, 0);
        step();
        chk("flush_empty_ready", cmd_ready, 1);

        // counters: 300 hit pulses on bank1 saturate an 8-bit counter
        cnt_en = 1'b1; cnt_bank = 2'd1; cnt_sel = 2'd0;
        for (int i = 1; i <= 300; i++) begin
            hit_evt = 4'b0010;
            step();
`ifdef ICACHE_CTRL_PERF_CNT_EN
            exp_cnt = sat(i);
`else
            exp_cnt = 0;
`endif
            if (i == 1 || i == 10 || i == 255 || i == 300) chk("cnt_hit_bank1", cnt_rdata, exp_cnt);
        end
        hit_evt = '0;
        cnt_sel = 2'd1;
        chk("cnt_trans_bank1", cnt_rdata, 0);
        cnt_sel = 2'd0;

        // CLEAR_CNT coincident with a hit: clear wins
        sb.push_back('{"clr_enabled", 4'b0100});
        hit_evt = 4'b0010;
        issue(2'd3, 4'b0010);
        hit_evt = '0;
        chk("clr_cnt_zero", cnt_rdata, 0);
        chk("clr_done", done, 1);
        step();
        chk("clr_ready", cmd_ready, 1);

        // disabled counting ignores events; misses count on their own counter
        cnt_en = 1'b0;
        hit_evt = 4'b0010;
        step(3);
        hit_evt = '0;
        chk("cnt_gated", cnt_rdata, 0);
        cnt_en = 1'b1;
        miss_evt = 4'b0010;
        step(2);
        miss_evt = '0;
        cnt_sel = 2'd2;
`ifdef ICACHE_CTRL_PERF_CNT_EN
        exp_cnt = 2;
`else
        exp_cnt = 0;
`endif
        chk("cnt_miss_bank1", cnt_rdata, exp_cnt);
        cnt_sel = 2'd3;
        chk("cnt_sel3_zero", cnt_rdata, 0);

        // reset while in REQ: requests drop, no done, ready returns
        issue(2'd0, 4'b1000);
        chk("rstreq_req", req_en, 4'b1000);
        rst_n = 1'b0;
        step();
        chk("rstreq_req_drop", req_en, 0);
        chk("rstreq_ready", cmd_ready, 1);
        chk("rstreq_no_done", done, 0);
        chk("rstreq_enabled", enabled, 0);
        rst_n = 1'b1;
        step();

        // minimum latency: both banks ack in the first REQ cycle
        sb.push_back('{"en_fast_enabled", 4'b0011});
        issue(2'd0, 4'b0011);
        chk("fast_req", req_en, 4'b0011);
        ack_en = 4'b0011;
        step();
        ack_en = '0;
        chk("fast_done", done, 1);
        step();
        chk("fast_ready", cmd_ready, 1);
        step(2);

        chk("sb_empty", sb.size(), 0);
        chk("done_count", n_done, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
